stop_watch_counter: RTL and testbench
=====================================

// Module: stop_watch_counter
// PURPOSE
//  BCD stopwatch feeding the 6-digit seven-segment display stage (stop_watch_num, shown when model==2'b10).
//  Counts MM:SS:CC (minutes 00-59, seconds 00-59, centiseconds 00-99) from a 10 ms prescaler.
//  Start/stop and clear come from debounced single-cycle key pulses, honoured only in stopwatch mode.
//  Counting keeps running in the background when another mode is shown.
// PARAMETERS
//  TICK_DIV   500_000  clk cycles per centisecond tick (50 MHz / 100); bench uses 4
//  CNT_W      19       prescaler width; must hold TICK_DIV-1
// PORTS
//  clk             in   1   system clock; the only clock
//  rst             in   1   reset, synchronous, active-high
//  model           in   2   display mode; keys act only when model==2'b10
//  key_start_stop  in   1   1-cycle pulse: toggle RUN/PAUSE, or start from IDLE
//  key_clear       in   1   1-cycle pulse: return to 00:00.00 / IDLE
//  key_lap         in   1   1-cycle pulse: lap freeze toggle (present only with STOPWATCH_LAP_EN)
//  stop_watch_num  out  24  BCD {M1,M0,S1,S0,C1,C0}, nibble [23:20] = tens of minutes
//  running         out  1   1 while in RUN
//  overflow        out  1   sticky; set when count saturates at 59:59.99
// BEHAVIOUR
//  Reset: state=IDLE, count=24'h000000, prescaler=0, stop_watch_num=24'h000000, running=0, overflow=0.
//  States: IDLE (count zero, prescaler 0), RUN (prescaler counts), PAUSE (count and prescaler held).
//   IDLE  --start_stop--> RUN;  RUN --start_stop--> PAUSE;  PAUSE --start_stop--> RUN.
//   any   --clear--> IDLE (count, prescaler, overflow cleared).  Clear wins over start_stop same cycle.
//   RUN   --count reaches 59:59.99 at a tick--> PAUSE, overflow=1 (saturate, no wrap).
//   PAUSE with overflow=1 ignores start_stop; only clear leaves it.
//  Key gating: a pulse with model!=2'b10 is ignored entirely (no state or count effect).
//  Prescaler: in RUN counts 0..TICK_DIV-1; tick when it equals TICK_DIV-1, then wraps to 0.
//   Held (not cleared) across PAUSE so resume loses no partial tick.
//  Digit chain on tick: C0 9->0 carries C1; C1 9->0 carries S0; S0 9->0 carries S1; S1 5->0 carries M0;
//   M0 9->0 carries M1; M1 5 with all lower at max -> saturate (see above). All digits stay valid BCD.
//  Latency: key pulse at edge N -> state/running change visible after edge N+1 (registered);
//   tick at edge N -> stop_watch_num shows new value after edge N+1. stop_watch_num is registered.
//  Tick and start_stop same cycle in RUN: tick is applied, then PAUSE.
//  rst asserted mid-count: all state returns to reset values at next edge regardless of keys.
// CONFIGURATION
//  `STOPWATCH_LAP_EN defined: key_lap port exists; in RUN/PAUSE a gated key_lap toggles a lap flag;
//   while lap=1 stop_watch_num holds the value captured at the lap press, internal count continues;
//   second key_lap (or clear) releases, output tracks count again next cycle. Lap ignored in IDLE.
//  Not defined: no key_lap port; stop_watch_num always mirrors the internal count.
// STRUCTURE
//  Shared package shizhong_pkg: MODE_STOPWATCH=2'b10, state encodings SW_IDLE/SW_RUN/SW_PAUSE,
//   BCD limits (DIG_MAX_9=4'd9, DIG_MAX_5=4'd5), SW_MAX=24'h595999.
//  One sub-module bcd_digit_cnt #(MAX): single BCD digit, inputs inc/clr, outputs q[3:0], carry;
//   instantiated six times (MAX 9,9,9,5,9,5 for C0,C1,S0,S1,M0,M1).
// TESTING (TICK_DIV=4)
//  1 Reset, start_stop with model=2'b10, wait 400 cycles -> stop_watch_num=24'h000100, running=1.
//  2 Start_stop with model=2'b00 -> ignored: state stays IDLE, output 24'h000000.
//  3 Preload near 00:59.99 via run, one tick -> 24'h010000 (C/S carries into M0).
//  4 Run to 59:59.99 -> output 24'h595999 holds, running=0, overflow=1; start_stop ignored; clear -> 0.
//  5 Pause 2 cycles into a tick period, resume -> next increment exactly 2 cycles later (prescaler held).
//  6 start_stop+clear same cycle in RUN -> IDLE, 24'h000000; with LAP_EN: lap at 24'h000012 holds
//    output while count advances, second lap -> live count.

Source files
------------

// File: rtl/shizhong_pkg.sv
// Shared stopwatch definitions: display mode code, FSM states, BCD digit limits
// and the saturation points of the MM:SS:CC count.
package shizhong_pkg;

   localparam logic [1:0] MODE_STOPWATCH = 2'b10;

   typedef enum logic [1:0] {
      SW_IDLE  = 2'd0,
      SW_RUN   = 2'd1,
      SW_PAUSE = 2'd2
   } sw_state_e;

   localparam logic [3:0] DIG_MAX_9 = 4'd9;
   localparam logic [3:0] DIG_MAX_5 = 4'd5;

   // SW_PRE_MAX is the count one tick before saturation.
   localparam logic [23:0] SW_MAX     = 24'h595999;
   localparam logic [23:0] SW_PRE_MAX = 24'h595998;

endpackage

// File: rtl/bcd_digit_cnt.sv
// Single BCD digit counting 0..MAX; carry is combinational and marks the
// increment that wraps the digit back to zero.
module bcd_digit_cnt
   import shizhong_pkg::*;
#(
   parameter logic [3:0] MAX = DIG_MAX_9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       clr,
   output logic [3:0] q,
   output logic       carry
);

   assign carry = inc && (q == MAX);

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= 4'd0;
      end else if (inc) begin
         q <= carry ? 4'd0 : q + 4'd1;
      end
   end

endmodule

// File: rtl/stop_watch_counter.sv
// BCD stopwatch MM:SS:CC with 10 ms prescaler, IDLE/RUN/PAUSE control and
// saturation at 59:59.99. Define STOPWATCH_LAP_EN to add the lap-freeze key.
module stop_watch_counter
   import shizhong_pkg::*;
#(
   parameter int TICK_DIV = 500_000,
   parameter int CNT_W    = 19
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  model,
   input  logic        key_start_stop,
   input  logic        key_clear,
`ifdef STOPWATCH_LAP_EN
   input  logic        key_lap,
`endif
   output logic [23:0] stop_watch_num,
   output logic        running,
   output logic        overflow
);

   sw_state_e        state, state_nxt;
   logic [CNT_W-1:0] presc;
   logic             sel, ss, clr, tick, sat, sat_evt;
   logic [3:0]       c0, c1, s0, s1, m0, m1;
   logic             c0_cy, c1_cy, s0_cy, s1_cy, m0_cy, m1_cy;
   logic [23:0]      cnt, disp;

   // Keys only act while the stopwatch page is displayed.
   assign sel  = (model == MODE_STOPWATCH);
   assign ss   = key_start_stop && sel;
   assign clr  = key_clear && sel;

   assign tick = (state == SW_RUN) && (presc == CNT_W'(TICK_DIV - 1));
   assign cnt  = {m1, m0, s1, s0, c1, c0};
   assign sat  = tick && (cnt == SW_PRE_MAX);
   // m1_cy can only rise if the chain were ever pushed past 59:59.99; flag it.
   assign sat_evt = sat || m1_cy;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         presc <= '0;
      end else if (state == SW_RUN) begin
         presc <= tick ? '0 : presc + CNT_W'(1);
      end
   end

   bcd_digit_cnt #(.MAX(DIG_MAX_9)) u_c0 (.clk(clk), .rst(rst), .inc(tick),  .clr(clr), .q(c0), .carry(c0_cy));
   bcd_digit_cnt #(.MAX(DIG_MAX_9)) u_c1 (.clk(clk), .rst(rst), .inc(c0_cy), .clr(clr), .q(c1), .carry(c1_cy));
   bcd_digit_cnt #(.MAX(DIG_MAX_9)) u_s0 (.clk(clk), .rst(rst), .inc(c1_cy), .clr(clr), .q(s0), .carry(s0_cy));
   bcd_digit_cnt #(.MAX(DIG_MAX_5)) u_s1 (.clk(clk), .rst(rst), .inc(s0_cy), .clr(clr), .q(s1), .carry(s1_cy));
   bcd_digit_cnt #(.MAX(DIG_MAX_9)) u_m0 (.clk(clk), .rst(rst), .inc(s1_cy), .clr(clr), .q(m0), .carry(m0_cy));
   bcd_digit_cnt #(.MAX(DIG_MAX_5)) u_m1 (.clk(clk), .rst(rst), .inc(m0_cy), .clr(clr), .q(m1), .carry(m1_cy));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SW_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: defaults are assigned first so no path through the block infers a latch.
   always_comb begin
      state_nxt = state;
      running   = (state == SW_RUN);
      case (state)
         SW_IDLE:  if (ss) state_nxt = SW_RUN;
         SW_RUN:   if (sat_evt || ss) state_nxt = SW_PAUSE;
         SW_PAUSE: if (ss && !overflow) state_nxt = SW_RUN;
         default:  state_nxt = SW_IDLE;
      endcase
      if (clr) state_nxt = SW_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         overflow <= 1'b0;
      end else if (sat_evt) begin
         overflow <= 1'b1;
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic        lap, lap_key;
   logic [23:0] lap_val;

   assign lap_key = key_lap && sel;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         lap     <= 1'b0;
         lap_val <= '0;
      end else if (lap_key && (state != SW_IDLE)) begin
         lap <= ~lap;
         if (!lap) lap_val <= cnt;
      end
   end

   assign disp = lap ? lap_val : cnt;
`else
   assign disp = cnt;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         stop_watch_num <= '0;
      end else begin
         stop_watch_num <= disp;
      end
   end

endmodule

// File: tb/tb_stop_watch_counter.sv
// Directed bench for stop_watch_counter with TICK_DIV=4; define
// STOPWATCH_LAP_EN on both RTL and bench to exercise the lap freeze.
module tb_stop_watch_counter;

   localparam int TICK_DIV = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  model;
   logic        key_start_stop;
   logic        key_clear;
`ifdef STOPWATCH_LAP_EN
   logic        key_lap;
`endif
   logic [23:0] stop_watch_num;
   logic        running;
   logic        overflow;

   logic [23:0] preload_v;
   int          errors = 0;
   int          checks = 0;
   int          n;

   always #5 clk = ~clk;

   stop_watch_counter #(.TICK_DIV(TICK_DIV), .CNT_W(19)) dut (
      .clk            (clk),
      .rst            (rst),
      .model          (model),
      .key_start_stop (key_start_stop),
      .key_clear      (key_clear),
`ifdef STOPWATCH_LAP_EN
      .key_lap        (key_lap),
`endif
      .stop_watch_num (stop_watch_num),
      .running        (running),
      .overflow       (overflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance n edges; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic cyc(input int cnt = 1);
      repeat (cnt) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press_ss();
      key_start_stop = 1'b1;
      cyc();
      key_start_stop = 1'b0;
   endtask

   task automatic press_clr();
      key_clear = 1'b1;
      cyc();
      key_clear = 1'b0;
   endtask

`ifdef STOPWATCH_LAP_EN
   task automatic press_lap();
      key_lap = 1'b1;
      cyc();
      key_lap = 1'b0;
   endtask
`endif

   task automatic wait_change(input logic [23:0] from, input int limit, output int cnt);
      cnt = 0;
      while (stop_watch_num === from && cnt < limit) begin
         cyc();
         cnt++;
      end
   endtask

   task automatic wait_val(input logic [23:0] v, input int limit, output int cnt);
      cnt = 0;
      while (stop_watch_num !== v && cnt < limit) begin
         cyc();
         cnt++;
      end
   endtask

   // Loads the digit registers while the counter is paused.
   task automatic preload(input logic [23:0] v);
      preload_v = v;
      force dut.u_m1.q = preload_v[23:20];
      force dut.u_m0.q = preload_v[19:16];
      force dut.u_s1.q = preload_v[15:12];
      force dut.u_s0.q = preload_v[11:8];
      force dut.u_c1.q = preload_v[7:4];
      force dut.u_c0.q = preload_v[3:0];
      cyc();
      release dut.u_m1.q;
      release dut.u_m0.q;
      release dut.u_s1.q;
      release dut.u_s0.q;
      release dut.u_c1.q;
      release dut.u_c0.q;
      cyc();
   endtask

   initial begin
      rst            = 1'b1;
      model          = 2'b10;
      key_start_stop = 1'b0;
      key_clear      = 1'b0;
      preload_v      = '0;
`ifdef STOPWATCH_LAP_EN
      key_lap        = 1'b0;
`endif
      cyc(3);
      check("rst_num", stop_watch_num, 24'h000000);
      check("rst_running", running, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      rst = 1'b0;
      cyc();

      // Key pulse outside stopwatch mode.
      model = 2'b00;
      press_ss();
      cyc(10);
      check("gate_running", running, 1'b0);
      check("gate_num", stop_watch_num, 24'h000000);
      model = 2'b10;

      // One second of counting: tick k lands on edge 4k after the start edge.
      press_ss();
      cyc(400);
      check("run_99", stop_watch_num, 24'h000099);
      cyc();
      check("run_100", stop_watch_num, 24'h000100);
      check("run_running", running, 1'b1);

      // Clear and start_stop ignored while another mode is shown.
      model = 2'b01;
      press_clr();
      press_ss();
      cyc();
      check("gate_run_num", stop_watch_num, 24'h000100);
      check("gate_run_running", running, 1'b1);
      model = 2'b10;

      // Carry from 00:59.99 into minutes.
      press_ss();
      check("pause_running", running, 1'b0);
      preload(24'h005999);
      check("preload_a", stop_watch_num, 24'h005999);
      press_ss();
      wait_change(24'h005999, 12, n);
      check("carry_min", stop_watch_num, 24'h010000);

      // Saturation at 59:59.99.
      press_ss();
      preload(24'h595998);
      check("preload_b", stop_watch_num, 24'h595998);
      press_ss();
      wait_change(24'h595998, 12, n);
      check("sat_num", stop_watch_num, 24'h595999);
      check("sat_running", running, 1'b0);
      check("sat_overflow", overflow, 1'b1);
      cyc(10);
      check("sat_hold", stop_watch_num, 24'h595999);
      press_ss();
      cyc(5);
      check("sat_ss_running", running, 1'b0);
      check("sat_ss_num", stop_watch_num, 24'h595999);
      model = 2'b00;
      press_clr();
      cyc();
      check("sat_gated_clr", overflow, 1'b1);
      model = 2'b10;
      press_clr();
      cyc();
      check("clr_num", stop_watch_num, 24'h000000);
      check("clr_overflow", overflow, 1'b0);
      check("clr_running", running, 1'b0);

      // Pause two cycles into a tick period; the held prescaler finishes it.
      press_ss();
      wait_change(24'h000000, 12, n);
      check("p_first", stop_watch_num, 24'h000001);
      press_ss();
      cyc(6);
      check("p_hold_num", stop_watch_num, 24'h000001);
      check("p_hold_running", running, 1'b0);
      press_ss();
      wait_change(24'h000001, 20, n);
      check("p_resume_lat", n, 3);
      check("p_resume_num", stop_watch_num, 24'h000002);

      // start_stop on the tick edge: increment applied, then PAUSE.
      cyc(2);
      press_ss();
      cyc();
      check("tick_ss_num", stop_watch_num, 24'h000003);
      check("tick_ss_running", running, 1'b0);
      cyc(8);
      check("tick_ss_hold", stop_watch_num, 24'h000003);

      // Clear wins over start_stop in the same cycle.
      press_ss();
      cyc(3);
      key_start_stop = 1'b1;
      key_clear      = 1'b1;
      cyc();
      key_start_stop = 1'b0;
      key_clear      = 1'b0;
      cyc();
      check("both_num", stop_watch_num, 24'h000000);
      check("both_running", running, 1'b0);

`ifdef STOPWATCH_LAP_EN
      // Lap is ignored in IDLE, then freezes the display at 00:00.12.
      press_lap();
      press_ss();
      wait_val(24'h000012, 100, n);
      check("lap_reach", stop_watch_num, 24'h000012);
      press_lap();
      cyc();
      check("lap_frozen", stop_watch_num, 24'h000012);
      cyc(39);
      check("lap_hold", stop_watch_num, 24'h000012);
      press_lap();
      cyc();
      check("lap_release", stop_watch_num, 24'h000022);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
